// File: rtl/ddr_frame_writer_mc.sv
// Multi-channel frame writer: round-robin arbitration of NUM_CH FWFT pixel FIFOs into
// single-outstanding INCR write bursts on the DdrCtrl AXI port 0, with per-channel frame buffer rotation.
module ddr_frame_writer_mc #(
    parameter int NUM_CH      = 2,
    parameter int DATA_W      = 128,
    parameter int ADDR_W      = 32,
    parameter int BURST_LEN   = 64,
    parameter int FRAME_BEATS = 115200,
    parameter int FB_NUM      = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0,
    parameter logic [ADDR_W-1:0] CH_STRIDE = 32'h0100_0000,
    parameter logic [ADDR_W-1:0] FB_STRIDE = 32'h0040_0000
) (
    input  logic                     Axi0Clk,
    input  logic                     rst_i,
    input  logic [NUM_CH-1:0]        ch_vs_i,
    input  logic [NUM_CH*16-1:0]     ch_cnt_i,
    input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
    output logic [NUM_CH-1:0]        ch_rd_en_o,
    output logic [NUM_CH*2-1:0]      fb_done_idx_o,
    output logic [NUM_CH-1:0]        frame_done_o,
    output logic [NUM_CH-1:0]        frame_drop_o,
    output logic [ADDR_W-1:0]        DdrCtrl_AADDR_0,
    output logic [7:0]               DdrCtrl_AID_0,
    output logic [7:0]               DdrCtrl_ALEN_0,
    output logic [2:0]               DdrCtrl_ASIZE_0,
    output logic [1:0]               DdrCtrl_ABURST_0,
    output logic [1:0]               DdrCtrl_ALOCK_0,
    output logic                     DdrCtrl_ATYPE_0,
    output logic                     DdrCtrl_AVALID_0,
    input  logic                     DdrCtrl_AREADY_0,
    output logic [DATA_W-1:0]        DdrCtrl_WDATA_0,
    output logic [7:0]               DdrCtrl_WID_0,
    output logic [DATA_W/8-1:0]      DdrCtrl_WSTRB_0,
    output logic                     DdrCtrl_WLAST_0,
    output logic                     DdrCtrl_WVALID_0,
    input  logic                     DdrCtrl_WREADY_0,
    output logic                     DdrCtrl_BREADY_0,
    input  logic [7:0]               DdrCtrl_BID_0,
    input  logic                     DdrCtrl_BVALID_0,
    output logic                     DdrCtrl_RREADY_0
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {S_IDLE, S_GRANT, S_ADDR, S_DATA, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d, rr_q, rr_d;
    logic [8:0]        beat_q, beat_d;
    logic [NUM_CH-1:0] armed_q, armed_d, restart_q, restart_d;
    logic [NUM_CH-1:0] drop_q, drop_d, done_q, done_d;
    logic [31:0]       off_q [NUM_CH];
    logic [31:0]       off_d [NUM_CH];
    logic [1:0]        widx_q [NUM_CH];
    logic [1:0]        widx_d [NUM_CH];
    logic [1:0]        fbidx_q [NUM_CH];
    logic [1:0]        fbidx_d [NUM_CH];

    logic              found, completing, unused_bid;
    int unsigned       idx;
    logic [31:0]       nxt_off;

    assign unused_bid = ^DdrCtrl_BID_0;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        beat_d     = beat_q;
        armed_d    = armed_q;
        restart_d  = restart_q;
        drop_d     = drop_q;
        done_d     = '0;
        off_d      = off_q;
        widx_d     = widx_q;
        fbidx_d    = fbidx_q;
        found      = 1'b0;
        idx        = 0;
        nxt_off    = '0;
        completing = 1'b0;
        ch_rd_en_o       = '0;
        DdrCtrl_AVALID_0 = 1'b0;
        DdrCtrl_WVALID_0 = 1'b0;
        DdrCtrl_WLAST_0  = 1'b0;
        DdrCtrl_BREADY_0 = 1'b0;

        case (state_q)
            S_IDLE: begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    idx = (32'(rr_q) + i) % 32'(NUM_CH);
                    if (!found && armed_q[idx] && ch_cnt_i[idx*16 +: 16] >= 16'(BURST_LEN)) begin
                        found   = 1'b1;
                        grant_d = CH_W'(idx);
                    end
                end
                if (found) state_d = S_GRANT;
            end
            S_GRANT: state_d = S_ADDR;
            S_ADDR: begin
                DdrCtrl_AVALID_0 = 1'b1;
                if (DdrCtrl_AREADY_0) begin
                    state_d = S_DATA;
                    beat_d  = '0;
                end
            end
            S_DATA: begin
                DdrCtrl_WVALID_0    = 1'b1;
                DdrCtrl_WLAST_0     = (beat_q == 9'(BURST_LEN - 1));
                ch_rd_en_o[grant_q] = DdrCtrl_WREADY_0;
                if (DdrCtrl_WREADY_0) begin
                    beat_d = beat_q + 9'd1;
                    if (DdrCtrl_WLAST_0) state_d = S_RESP;
                end
            end
            S_RESP: begin
                DdrCtrl_BREADY_0 = 1'b1;
                if (DdrCtrl_BVALID_0) begin
                    completing = 1'b1;
                    nxt_off    = off_q[grant_q] + 32'(BURST_LEN);
                    if (nxt_off == 32'(FRAME_BEATS)) begin
                        fbidx_d[grant_q] = widx_q[grant_q];
                        done_d[grant_q]  = 1'b1;
                        widx_d[grant_q]  = (widx_q[grant_q] == 2'(FB_NUM - 1)) ? 2'd0 : widx_q[grant_q] + 2'd1;
                        off_d[grant_q]   = '0;
                        armed_d[grant_q] = 1'b0;
                    end else begin
                        off_d[grant_q] = nxt_off;
                    end
                    // A frame start that landed during this burst takes effect now
                    if (restart_q[grant_q]) begin
                        restart_d[grant_q] = 1'b0;
                        off_d[grant_q]     = '0;
                        armed_d[grant_q]   = 1'b1;
                    end
                    rr_d    = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Frame starts are applied on top of any burst completion in the same cycle
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch_vs_i[c]) begin
                if (state_q != S_IDLE && grant_q == CH_W'(c) && !completing) begin
                    drop_d[c]    = 1'b1;
                    restart_d[c] = 1'b1;
                end else begin
                    if (armed_d[c] && off_d[c] != '0) drop_d[c] = 1'b1;
                    armed_d[c] = 1'b1;
                    off_d[c]   = '0;
                end
            end
        end
    end

    always_ff @(posedge Axi0Clk or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            rr_q      <= '0;
            beat_q    <= '0;
            armed_q   <= '0;
            restart_q <= '0;
            drop_q    <= '0;
            done_q    <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                off_q[c]   <= '0;
                widx_q[c]  <= '0;
                fbidx_q[c] <= '0;
            end
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            beat_q    <= beat_d;
            armed_q   <= armed_d;
            restart_q <= restart_d;
            drop_q    <= drop_d;
            done_q    <= done_d;
            off_q     <= off_d;
            widx_q    <= widx_d;
            fbidx_q   <= fbidx_d;
        end
    end

    always_comb begin
        fb_done_idx_o = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) fb_done_idx_o[c*2 +: 2] = fbidx_q[c];
    end

    assign frame_done_o     = done_q;
    assign frame_drop_o     = drop_q;
    assign DdrCtrl_AADDR_0  = BASE_ADDR + ADDR_W'(grant_q) * CH_STRIDE
                            + ADDR_W'(widx_q[grant_q]) * FB_STRIDE
                            + ADDR_W'(off_q[grant_q]) * ADDR_W'(STRB_W);
    assign DdrCtrl_AID_0    = 8'(grant_q);
    assign DdrCtrl_ALEN_0   = 8'(BURST_LEN - 1);
    assign DdrCtrl_ASIZE_0  = 3'($clog2(STRB_W));
    assign DdrCtrl_ABURST_0 = 2'b01;
    assign DdrCtrl_ALOCK_0  = 2'b00;
    assign DdrCtrl_ATYPE_0  = 1'b1;
    assign DdrCtrl_WDATA_0  = ch_data_i[32'(grant_q)*DATA_W +: DATA_W];
    assign DdrCtrl_WID_0    = 8'(grant_q);
    assign DdrCtrl_WSTRB_0  = '1;
    assign DdrCtrl_RREADY_0 = 1'b0;
endmodule
